mitm_eval_sequencer: RTL and testbench

Controller that sequences the MITM decision logic for each captured bus word. It latches the real MISO/MOSI pair from the bus receivers, clears and triggers the decision logic, and collects its fake data and select flags. It then presents the final per-lane word, fake or real, to the bus transmit stage under a valid/ready handshake. It sits between the SPI capture/replay shifters and the MITM decision logic.

---
 rtl/mitm_eval_sequencer_if.sv | 48 ++++
 rtl/mitm_eval_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mitm_eval_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mitm_eval_sequencer_if.sv
// Bus bundle between the MITM evaluation sequencer and its neighbours:
// the SPI receive path (rx_*), the MITM decision logic (logic_*), and the
// transmit stage (tx_*). The master modport is the sequencer's view.
interface mitm_eval_sequencer_if #(
  parameter int DATA_SIZE = 8
);
  // Receive side: real word pair from the bus receivers
  logic                 rx_valid;
  logic [DATA_SIZE-1:0] rx_miso_data;
  logic [DATA_SIZE-1:0] rx_mosi_data;

  // Decision logic side
  logic                 logic_rst;
  logic                 logic_eval;
  logic [DATA_SIZE-1:0] logic_miso_data;
  logic [DATA_SIZE-1:0] logic_mosi_data;
  logic [DATA_SIZE-1:0] logic_fake_miso_data;
  logic [DATA_SIZE-1:0] logic_fake_mosi_data;
  logic                 logic_fake_miso_select;
  logic                 logic_fake_mosi_select;
  logic                 logic_data_valid;

  // Transmit side: final word pair under valid/ready
  logic [DATA_SIZE-1:0] tx_miso_data;
  logic [DATA_SIZE-1:0] tx_mosi_data;
  logic                 tx_miso_fake;
  logic                 tx_mosi_fake;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    input  rx_valid, rx_miso_data, rx_mosi_data,
    output logic_rst, logic_eval, logic_miso_data, logic_mosi_data,
    input  logic_fake_miso_data, logic_fake_mosi_data,
    input  logic_fake_miso_select, logic_fake_mosi_select, logic_data_valid,
    output tx_miso_data, tx_mosi_data, tx_miso_fake, tx_mosi_fake, tx_valid,
    input  tx_ready
  );

  modport slave (
    output rx_valid, rx_miso_data, rx_mosi_data,
    input  logic_rst, logic_eval, logic_miso_data, logic_mosi_data,
    output logic_fake_miso_data, logic_fake_mosi_data,
    output logic_fake_miso_select, logic_fake_mosi_select, logic_data_valid,
    input  tx_miso_data, tx_mosi_data, tx_miso_fake, tx_mosi_fake, tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/mitm_eval_sequencer.sv
// MITM evaluation sequencer. For each captured word pair it latches the
// real MISO/MOSI words, clears then triggers the decision logic, collects
// the fake words and select flags, and offers the final per-lane word to
// the transmit stage under valid/ready.
// Optional feature: define MITM_TIMEOUT_EN to bound the wait for the
// decision logic; on expiry the real words are forwarded and timeout_err
// pulses for one cycle. Without it the wait is unbounded and timeout_err
// is tied low.
module mitm_eval_sequencer #(
  parameter int DATA_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  mitm_eval_sequencer_if.master        bus,
  output logic                         busy,
  output logic                         overrun,
  output logic                         timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    EVAL,
    WAIT,
    OUTPUT
  } state_t;

  // Reject a timeout that cannot be represented by the counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TIMEOUT_WIDTH) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range for TIMEOUT_WIDTH");
  end

  state_t               state_q, state_d;
  logic                 accept;    // take the rx word pair this cycle
  logic                 drop;      // rx word arrived while busy and is lost
  logic                 capture;   // decision result taken this cycle
  logic                 expire;    // wait for decision logic gave up
  logic                 tmo_hit;   // counter is on its last WAIT cycle

  logic                 logic_rst_q, logic_eval_q, tx_valid_q;
  logic                 tx_miso_fake_q, tx_mosi_fake_q;
  logic [DATA_SIZE-1:0] real_miso_q, real_mosi_q;
  logic [DATA_SIZE-1:0] tx_miso_q, tx_mosi_q;

`ifdef MITM_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in WAIT; restarted by every EVAL.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == EVAL)
        tmo_cnt_q <= '0;
      else if (state_q == WAIT && !tmo_hit)
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      timeout_err <= expire;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and per-cycle decisions.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          accept  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        drop    = bus.rx_valid;
        state_d = EVAL;
      end
      EVAL: begin
        drop    = bus.rx_valid;
        state_d = WAIT;
      end
      WAIT: begin
        drop = bus.rx_valid;
        // A valid result wins over a timeout expiring in the same cycle.
        if (bus.logic_data_valid) begin
          capture = 1'b1;
          state_d = OUTPUT;
        end else if (tmo_hit) begin
          expire  = 1'b1;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bus.tx_ready) begin
          // Back-to-back: a word arriving on the handshake cycle is kept.
          if (bus.rx_valid) begin
            accept  = 1'b1;
            state_d = CLEAR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          drop = bus.rx_valid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered strobes and the data path.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      logic_rst_q    <= 1'b0;
      logic_eval_q   <= 1'b0;
      tx_valid_q     <= 1'b0;
      real_miso_q    <= '0;
      real_mosi_q    <= '0;
      tx_miso_q      <= '0;
      tx_mosi_q      <= '0;
      tx_miso_fake_q <= 1'b0;
      tx_mosi_fake_q <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state_q      <= state_d;
      logic_rst_q  <= (state_d == CLEAR);
      logic_eval_q <= (state_d == EVAL);
      tx_valid_q   <= (state_d == OUTPUT);
      if (accept) begin
        real_miso_q <= bus.rx_miso_data;
        real_mosi_q <= bus.rx_mosi_data;
      end
      if (capture) begin
        tx_miso_q      <= bus.logic_fake_miso_select ? bus.logic_fake_miso_data : real_miso_q;
        tx_mosi_q      <= bus.logic_fake_mosi_select ? bus.logic_fake_mosi_data : real_mosi_q;
        tx_miso_fake_q <= bus.logic_fake_miso_select;
        tx_mosi_fake_q <= bus.logic_fake_mosi_select;
      end else if (expire) begin
        tx_miso_q      <= real_miso_q;
        tx_mosi_q      <= real_mosi_q;
        tx_miso_fake_q <= 1'b0;
        tx_mosi_fake_q <= 1'b0;
      end
      if (drop)
        overrun <= 1'b1;
    end
  end

  assign busy                = (state_q != IDLE);
  assign bus.logic_rst       = logic_rst_q;
  assign bus.logic_eval      = logic_eval_q;
  assign bus.logic_miso_data = real_miso_q;
  assign bus.logic_mosi_data = real_mosi_q;
  assign bus.tx_miso_data    = tx_miso_q;
  assign bus.tx_mosi_data    = tx_mosi_q;
  assign bus.tx_miso_fake    = tx_miso_fake_q;
  assign bus.tx_mosi_fake    = tx_mosi_fake_q;
  assign bus.tx_valid        = tx_valid_q;

endmodule

// File: tb/tb_mitm_eval_sequencer.sv
// Self-checking bench for mitm_eval_sequencer: directed steps from the
// test plan followed by randomized words, checked against a word-level
// reference (final lane = select ? fake : real, fixed cycle positions).
module tb_mitm_eval_sequencer;

  localparam int DATA_SIZE = 8;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic busy, overrun, timeout_err;

  int checks   = 0;
  int failures = 0;
  bit exp_overrun = 1'b0;

  mitm_eval_sequencer_if #(.DATA_SIZE(DATA_SIZE)) bus ();

  mitm_eval_sequencer #(
    .DATA_SIZE     (DATA_SIZE),
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_WIDTH (8)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: a lane carries the fake word only when selected.
  function automatic logic [7:0] lane_word(input logic sel, input logic [7:0] fake, input logic [7:0] real_w);
    return sel ? fake : real_w;
  endfunction

  task automatic send(input logic [7:0] miso, input logic [7:0] mosi);
    @(negedge sys_clk);
    bus.rx_valid     = 1'b1;
    bus.rx_miso_data = miso;
    bus.rx_mosi_data = mosi;
  endtask

  // Follows one accepted word from CLEAR through OUTPUT. The rx pulse must
  // already be on the bus for the accepting edge.
  task automatic finish_word(input logic [7:0] miso, input logic [7:0] mosi,
                             input logic [7:0] fmiso, input logic [7:0] fmosi,
                             input logic smiso, input logic smosi,
                             input int dly, input int stall,
                             input bit inject, input bit complete);
    logic [7:0] exp_miso, exp_mosi;
    exp_miso = lane_word(smiso, fmiso, miso);
    exp_mosi = lane_word(smosi, fmosi, mosi);

    @(negedge sys_clk);   // CLEAR
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    check("clear_logic_rst", bus.logic_rst, 1);
    check("clear_logic_eval", bus.logic_eval, 0);
    check("latch_miso", bus.logic_miso_data, miso);
    check("latch_mosi", bus.logic_mosi_data, mosi);
    check("clear_tx_valid", bus.tx_valid, 0);
    check("clear_busy", busy, 1);
    check("clear_overrun", overrun, exp_overrun);

    @(negedge sys_clk);   // EVAL; decision logic drops its stale result now
    bus.logic_data_valid = 1'b0;
    check("eval_logic_eval", bus.logic_eval, 1);
    check("eval_logic_rst", bus.logic_rst, 0);

    @(negedge sys_clk);   // WAIT
    check("wait_tx_valid", bus.tx_valid, 0);
    check("wait_strobes", {bus.logic_rst, bus.logic_eval}, 0);
    for (int i = 0; i < dly; i++) begin
      @(negedge sys_clk);
      check("wait_ext_tx_valid", bus.tx_valid, 0);
    end
    bus.logic_data_valid       = 1'b1;
    bus.logic_fake_miso_data   = fmiso;
    bus.logic_fake_mosi_data   = fmosi;
    bus.logic_fake_miso_select = smiso;
    bus.logic_fake_mosi_select = smosi;

    @(negedge sys_clk);   // OUTPUT
    check("out_tx_valid", bus.tx_valid, 1);
    check("out_miso", bus.tx_miso_data, exp_miso);
    check("out_mosi", bus.tx_mosi_data, exp_mosi);
    check("out_miso_fake", bus.tx_miso_fake, smiso);
    check("out_mosi_fake", bus.tx_mosi_fake, smosi);
    check("out_timeout_err", timeout_err, 0);
    // Disturb the decision inputs; the presented word must not follow.
    bus.logic_fake_miso_data   = ~fmiso;
    bus.logic_fake_mosi_data   = ~fmosi;
    bus.logic_fake_miso_select = ~smiso;
    bus.logic_fake_mosi_select = ~smosi;

    for (int i = 0; i < stall; i++) begin
      if (inject && i == 1) begin
        bus.rx_valid     = 1'b1;
        bus.rx_miso_data = ~miso;
        bus.rx_mosi_data = ~mosi;
      end
      @(negedge sys_clk);
      bus.rx_valid = 1'b0;
      if (inject && i == 1) exp_overrun = 1'b1;
      check("stall_tx_valid", bus.tx_valid, 1);
      check("stall_miso", bus.tx_miso_data, exp_miso);
      check("stall_mosi", bus.tx_mosi_data, exp_mosi);
      check("stall_fake", {bus.tx_miso_fake, bus.tx_mosi_fake}, {smiso, smosi});
      check("stall_latched_miso", bus.logic_miso_data, miso);
      check("stall_overrun", overrun, exp_overrun);
    end

    if (complete) begin
      bus.tx_ready = 1'b1;
      @(negedge sys_clk); // back in IDLE
      bus.tx_ready = 1'b0;
      check("done_tx_valid", bus.tx_valid, 0);
      check("done_busy", busy, 0);
    end
  endtask

  initial begin
    logic [7:0] r_miso, r_mosi, r_fmiso, r_fmosi;
    logic       r_smiso, r_smosi;
    int         wait_cycles;

    bus.rx_valid               = 1'b0;
    bus.rx_miso_data           = '0;
    bus.rx_mosi_data           = '0;
    bus.logic_fake_miso_data   = '0;
    bus.logic_fake_mosi_data   = '0;
    bus.logic_fake_miso_select = 1'b0;
    bus.logic_fake_mosi_select = 1'b0;
    bus.logic_data_valid       = 1'b0;
    bus.tx_ready               = 1'b0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_busy", busy, 0);
    check("rst_outputs", {bus.logic_rst, bus.logic_eval, bus.tx_valid, overrun, timeout_err}, 0);
    check("rst_tx_data", {bus.tx_miso_data, bus.tx_mosi_data}, 0);
    check("rst_logic_data", {bus.logic_miso_data, bus.logic_mosi_data}, 0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle_busy", busy, 0);

    // Plain pass-through word, minimum latency
    send(8'hA5, 8'h3C);
    finish_word(8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Fake MISO only
    send(8'hA5, 8'h3C);
    finish_word(8'hA5, 8'h3C, 8'hFF, 8'h11, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);

    // Back-to-back: second word accepted on the handshake cycle
    send(8'h5A, 8'hC3);
    finish_word(8'h5A, 8'hC3, 8'h22, 8'h99, 1'b0, 1'b1, 1, 2, 1'b0, 1'b0);
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_miso_data = 8'h0F;
    bus.rx_mosi_data = 8'hF0;
    finish_word(8'h0F, 8'hF0, 8'h77, 8'h88, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1);
    check("b2b_overrun", overrun, 0);

    // Transmit stall with a dropped word in the window
    send(8'h81, 8'h42);
    finish_word(8'h81, 8'h42, 8'hEE, 8'hDD, 1'b0, 1'b1, 2, 5, 1'b1, 1'b1);
    check("overrun_sticky", overrun, 1);

    // Randomized words
    for (int n = 0; n < 16; n++) begin
      r_miso  = 8'($urandom);
      r_mosi  = 8'($urandom);
      r_fmiso = 8'($urandom);
      r_fmosi = 8'($urandom);
      r_smiso = 1'($urandom);
      r_smosi = 1'($urandom);
      send(r_miso, r_mosi);
      finish_word(r_miso, r_mosi, r_fmiso, r_fmosi, r_smiso, r_smosi,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b1);
    end

`ifdef MITM_TIMEOUT_EN
    // Decision logic never answers: fallback to the real words
    send(8'h6B, 8'h94);
    @(negedge sys_clk);
    bus.rx_valid = 1'b0;
    @(negedge sys_clk);
    bus.logic_data_valid       = 1'b0;
    bus.logic_fake_miso_select = 1'b1;
    bus.logic_fake_mosi_select = 1'b1;
    @(negedge sys_clk);   // first WAIT cycle
    wait_cycles = 0;
    while (bus.tx_valid !== 1'b1 && wait_cycles < 40) begin
      @(negedge sys_clk);
      wait_cycles++;
    end
    check("tmo_wait_cycles", wait_cycles, 16);
    check("tmo_miso", bus.tx_miso_data, 8'h6B);
    check("tmo_mosi", bus.tx_mosi_data, 8'h94);
    check("tmo_fake", {bus.tx_miso_fake, bus.tx_mosi_fake}, 0);
    check("tmo_err_pulse", timeout_err, 1);
    @(negedge sys_clk);
    check("tmo_err_single", timeout_err, 0);
    bus.tx_ready = 1'b1;
    @(negedge sys_clk);
    bus.tx_ready = 1'b0;
    check("tmo_done_tx_valid", bus.tx_valid, 0);
`endif

    // Asynchronous reset while in WAIT
    send(8'hC7, 8'h7C);
    @(negedge sys_clk);
    bus.rx_valid = 1'b0;
    @(negedge sys_clk);
    bus.logic_data_valid = 1'b0;
    @(negedge sys_clk);   // WAIT
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    check("arst_logic_data", {bus.logic_miso_data, bus.logic_mosi_data}, 0);
    check("arst_outputs", {bus.logic_rst, bus.logic_eval, bus.tx_valid, timeout_err}, 0);
    exp_overrun = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Normal operation after reset
    send(8'h3E, 8'hE3);
    finish_word(8'h3E, 8'hE3, 8'h12, 8'h34, 1'b1, 1'b1, 1, 1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
